// File: rtl/dclk_period_meter.sv
// Measures the period and high time of a clk_i-domain divided clock, in clk_i cycles.
// Ports: clk_i/rstn_i, dclk_i, start_i in; busy_o, done_o, timeout_o, period_o, high_o out.
module dclk_period_meter #(
   parameter int CNT_W   = 16,
   parameter int TMO_CYC = 65535
) (
   input  logic             clk_i,
   input  logic             rstn_i,
   input  logic             dclk_i,
   input  logic             start_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             timeout_o,
   output logic [CNT_W-1:0] period_o,
   output logic [CNT_W-1:0] high_o
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ARM,
      S_MEAS
   } state_t;

   localparam logic [CNT_W-1:0] LP_TMO = CNT_W'(TMO_CYC);
   localparam logic [CNT_W-1:0] LP_ONE = CNT_W'(1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_dclk_q;
   logic             r_done;
   logic             w_done_nxt;
   logic             r_tmo;
   logic             w_tmo_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [CNT_W-1:0] r_hcnt;
   logic [CNT_W-1:0] w_hcnt_nxt;
   logic [CNT_W-1:0] r_period;
   logic [CNT_W-1:0] w_period_nxt;
   logic [CNT_W-1:0] r_high;
   logic [CNT_W-1:0] w_high_nxt;

   logic             w_rise;
   logic [CNT_W-1:0] w_cnt_inc;
   logic [CNT_W-1:0] w_hcnt_add;

   // dclk_q resets high so a level already high at reset release is not an edge
   assign w_rise     = dclk_i & ~r_dclk_q;
   assign w_cnt_inc  = r_cnt + LP_ONE;
   assign w_hcnt_add = r_hcnt + {{(CNT_W-1){1'b0}}, dclk_i};

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         r_state  <= S_IDLE;
         r_dclk_q <= 1'b1;
         r_done   <= 1'b0;
         r_tmo    <= 1'b0;
         r_cnt    <= '0;
         r_hcnt   <= '0;
         r_period <= '0;
         r_high   <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_dclk_q <= dclk_i;
         r_done   <= w_done_nxt;
         r_tmo    <= w_tmo_nxt;
         r_cnt    <= w_cnt_nxt;
         r_hcnt   <= w_hcnt_nxt;
         r_period <= w_period_nxt;
         r_high   <= w_high_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_done_nxt   = 1'b0;
      w_tmo_nxt    = r_tmo;
      w_cnt_nxt    = r_cnt;
      w_hcnt_nxt   = r_hcnt;
      w_period_nxt = r_period;
      w_high_nxt   = r_high;
      unique case (r_state)
         S_IDLE: begin
            if (start_i) begin
               w_state_nxt  = S_ARM;
               w_tmo_nxt    = 1'b0;
               w_cnt_nxt    = '0;
               w_hcnt_nxt   = '0;
               w_period_nxt = '0;
               w_high_nxt   = '0;
            end
         end
         S_ARM: begin
            // the rise cycle itself is high and opens the period
            if (w_rise) begin
               w_state_nxt = S_MEAS;
               w_cnt_nxt   = LP_ONE;
               w_hcnt_nxt  = LP_ONE;
            end else if (w_cnt_inc == LP_TMO) begin
               w_state_nxt = S_IDLE;
               w_tmo_nxt   = 1'b1;
               w_done_nxt  = 1'b1;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = w_cnt_inc;
            end
         end
         S_MEAS: begin
            // rise checked first so a period of exactly TMO_CYC is valid
            if (w_rise) begin
               w_state_nxt  = S_IDLE;
               w_period_nxt = r_cnt;
               w_high_nxt   = r_hcnt;
               w_done_nxt   = 1'b1;
            end else if (r_cnt == LP_TMO) begin
               w_state_nxt = S_IDLE;
               w_tmo_nxt   = 1'b1;
               w_done_nxt  = 1'b1;
            end else begin
               w_cnt_nxt  = w_cnt_inc;
               w_hcnt_nxt = w_hcnt_add;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign busy_o    = (r_state != S_IDLE);
   assign done_o    = r_done;
   assign timeout_o = r_tmo;
   assign period_o  = r_period;
   assign high_o    = r_high;

endmodule

// File: tb/tb_dclk_period_meter.sv
// Directed bench for dclk_period_meter with TMO_CYC=100.
// Table of dclk patterns plus hand sequences for timeout, reset abort and start handling.
module tb_dclk_period_meter;

   localparam int CW  = 16;
   localparam int TMO = 100;

   logic          clk;
   logic          rstn;
   logic          dclk;
   logic          start;
   logic          busy;
   logic          done;
   logic          tmo;
   logic [CW-1:0] period;
   logic [CW-1:0] high;

   dclk_period_meter #(
      .CNT_W   (CW),
      .TMO_CYC (TMO)
   ) dut (
      .clk_i     (clk),
      .rstn_i    (rstn),
      .dclk_i    (dclk),
      .start_i   (start),
      .busy_o    (busy),
      .done_o    (done),
      .timeout_o (tmo),
      .period_o  (period),
      .high_o    (high)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // dclk pattern generator: hi_len==0 holds 0, lo_len==0 holds 1
   int hi_len = 0;
   int lo_len = 0;
   int ph     = 0;
   initial dclk = 1'b1;
   always @(negedge clk) begin
      if (hi_len == 0) begin
         dclk = 1'b0;
      end else if (lo_len == 0) begin
         dclk = 1'b1;
      end else begin
         ph   = (ph + 1) % (hi_len + lo_len);
         dclk = (ph < hi_len);
      end
   end

   int done_cnt = 0;
   always @(negedge clk) if (done) done_cnt++;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      int hi;
      int lo;
      bit start_hi;
      int e_per;
      int e_high;
      bit e_tmo;
   } vec_t;

   vec_t vecs[10];

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input longint act, input longint exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic pulse_start();
      step();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic wait_done(input int lim, output int cyc, output bit ok);
      ok  = 1'b0;
      cyc = 0;
      for (int k = 1; k <= lim; k++) begin
         step();
         if (done) begin
            ok  = 1'b1;
            cyc = k;
            break;
         end
      end
      if (!ok) begin
         n_chk++;
         n_fail++;
         $display("FAIL wait_done: got no done within %0d cycles, required done", lim);
      end
   endtask

   task automatic set_pat(input int h, input int l);
      hi_len = h;
      lo_len = l;
      repeat (250) step();
   endtask

   int  cyc;
   bit  ok;
   int  d0;
   bit  prev;
   bit  seen;

   initial begin
      vecs[0] = '{1, 1, 1'b0, 2, 1, 1'b0};
      vecs[1] = '{8, 8, 1'b1, 16, 8, 1'b0};
      vecs[2] = '{3, 5, 1'b0, 8, 3, 1'b0};
      vecs[3] = '{1, 9, 1'b1, 10, 1, 1'b0};
      vecs[4] = '{50, 50, 1'b0, 100, 50, 1'b0};
      vecs[5] = '{50, 51, 1'b0, 0, 0, 1'b1};
      vecs[6] = '{0, 0, 1'b0, 0, 0, 1'b1};
      vecs[7] = '{5, 0, 1'b1, 0, 0, 1'b1};
      vecs[8] = '{99, 1, 1'b1, 100, 99, 1'b0};
      vecs[9] = '{1, 98, 1'b0, 99, 1, 1'b0};

      // reset with dclk held high
      hi_len = 5;
      lo_len = 0;
      rstn   = 1'b0;
      start  = 1'b0;
      repeat (3) step();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_tmo", tmo, 0);
      chk("rst_period", period, 0);
      chk("rst_high", high, 0);
      rstn = 1'b1;
      repeat (5) step();
      chk("rst_rel_busy", busy, 0);
      chk("rst_rel_done_cnt", done_cnt, 0);

      for (int i = 0; i < 10; i++) begin
         set_pat(vecs[i].hi, vecs[i].lo);
         if (vecs[i].start_hi) begin
            for (int k = 0; k < 300 && !dclk; k++) step();
         end
         d0 = done_cnt;
         pulse_start();
         chk($sformatf("v%0d_busy", i), busy, 1);
         wait_done(400, cyc, ok);
         chk($sformatf("v%0d_period", i), period, vecs[i].e_per);
         chk($sformatf("v%0d_high", i), high, vecs[i].e_high);
         chk($sformatf("v%0d_tmo", i), tmo, vecs[i].e_tmo);
         chk($sformatf("v%0d_idle", i), busy, 0);
         repeat (5) step();
         chk($sformatf("v%0d_ndone", i), done_cnt - d0, 1);
      end

      // exact timeout latency from ARM entry, dclk held low
      set_pat(0, 0);
      pulse_start();
      wait_done(300, cyc, ok);
      chk("tmo_latency", cyc, TMO);
      chk("tmo_flag", tmo, 1);
      chk("tmo_period", period, 0);

      // reset during MEAS with dclk high
      set_pat(8, 8);
      step();
      while (dclk) step();
      pulse_start();
      prev = dclk;
      seen = 1'b0;
      for (int k = 0; k < 100; k++) begin
         step();
         if (dclk && !prev) begin
            seen = 1'b1;
            break;
         end
         prev = dclk;
      end
      chk("rab_rise_seen", seen, 1);
      repeat (2) step();
      chk("rab_busy_pre", busy, 1);
      chk("rab_dclk_hi", dclk, 1);
      d0   = done_cnt;
      rstn = 1'b0;
      step();
      rstn = 1'b1;
      chk("rab_busy", busy, 0);
      chk("rab_done", done, 0);
      chk("rab_period", period, 0);
      chk("rab_high", high, 0);
      chk("rab_tmo", tmo, 0);
      repeat (30) step();
      chk("rab_ndone", done_cnt - d0, 0);
      chk("rab_period2", period, 0);
      pulse_start();
      wait_done(400, cyc, ok);
      chk("rab_re_period", period, 16);
      chk("rab_re_high", high, 8);
      chk("rab_re_tmo", tmo, 0);

      // start pulsed repeatedly while busy gives one measurement
      set_pat(8, 8);
      d0 = done_cnt;
      pulse_start();
      for (int k = 0; k < 4; k++) begin
         pulse_start();
         step();
      end
      wait_done(400, cyc, ok);
      chk("bsy_period", period, 16);
      repeat (60) step();
      chk("bsy_ndone", done_cnt - d0, 1);
      chk("bsy_idle", busy, 0);

      // start held high: restart on every done cycle
      set_pat(1, 1);
      step();
      start = 1'b1;
      for (int m = 0; m < 3; m++) begin
         wait_done(400, cyc, ok);
         chk($sformatf("hold%0d_period", m), period, 2);
         chk($sformatf("hold%0d_high", m), high, 1);
         chk($sformatf("hold%0d_tmo", m), tmo, 0);
         step();
         chk($sformatf("hold%0d_restart", m), busy, 1);
         chk($sformatf("hold%0d_clr", m), period, 0);
      end
      start = 1'b0;
      wait_done(400, cyc, ok);
      repeat (20) step();
      chk("hold_end_idle", busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/dclk_period_meter.md
DCLK_PERIOD_METER -- requirements
Module: dclk_period_meter

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the period/high-time counters and results.
REQ-002 SHALL have parameter TMO_CYC, default 65535, the clk_i-cycle limit per phase; legal range 2 .. 2^CNT_W-1.
REQ-003 SHALL have port clk_i, input, 1, the single system clock; all logic on its rising edge.
REQ-004 SHALL have port rstn_i, input, 1, synchronous active-low reset.
REQ-005 SHALL have port dclk_i, input, 1, divided/gated clock under test, generated in the clk_i domain and treated as data, not as a clock.
REQ-006 SHALL have port start_i, input, 1, single-cycle request to start one measurement.
REQ-007 SHALL have port busy_o, output, 1, high while a measurement is in progress.
REQ-008 SHALL have port done_o, output, 1, one-cycle pulse when a measurement ends, whether completed or timed out.
REQ-009 SHALL have port timeout_o, output, 1, status of the last measurement, held until the next accepted start.
REQ-010 SHALL have port period_o, output, CNT_W, clk_i cycles between two consecutive dclk_i rising edges.
REQ-011 SHALL have port high_o, output, CNT_W, clk_i cycles dclk_i was high within that period.

Function
REQ-012 SHALL register dclk_i every cycle into dclk_q, independent of state; rise = dclk_i & ~dclk_q.
REQ-013 SHALL implement states IDLE, ARM and MEAS; busy_o = (state != IDLE), decoded from the state register.
REQ-014 IDLE SHALL go to ARM on start_i=1, clearing timeout_o, period_o, high_o and the cycle counter; start_i SHALL be ignored whenever busy_o=1.
REQ-015 ARM SHALL wait for rise and count cycles spent waiting; at rise it SHALL go to MEAS with cnt=1, hcnt=1.
REQ-016 MEAS on a cycle without rise SHALL do cnt<=cnt+1 and hcnt<=hcnt+dclk_i.
REQ-017 MEAS on rise SHALL load period_o<=cnt and high_o<=hcnt, pulse done_o, and return to IDLE; result: rise at t and t+P gives period_o=P.
REQ-018 SHALL time out when the ARM wait count or the MEAS cnt reaches TMO_CYC without a rise: set timeout_o=1, keep period_o=high_o=0, pulse done_o, return to IDLE.
REQ-019 If rise and the timeout limit occur in the same MEAS cycle, the rise SHALL win, giving a valid result with period_o=TMO_CYC.
REQ-020 done_o SHALL be registered and coincide with the first IDLE cycle (busy_o=0); start_i in that same cycle SHALL be accepted.
REQ-021 A dclk_i already high when start_i is accepted SHALL NOT count as an edge; only a 0->1 transition arms the measurement.
REQ-022 Counters SHALL never wrap; the timeout limit TMO_CYC <= 2^CNT_W-1 guarantees this.
REQ-023 dclk_i held at 0 or at 1 (oe gated off, or stalled) SHALL end in timeout, never a hang.

Reset
REQ-024 With rstn_i=0 at a clk_i edge, the block SHALL set state=IDLE; busy_o, done_o, timeout_o = 0; period_o, high_o, all counters = 0; dclk_q = 1.
REQ-025 dclk_q reset to 1 SHALL prevent a spurious rise when dclk_i is high on reset release.
REQ-026 Reset asserted during ARM or MEAS SHALL abort without a done_o pulse; results read 0 afterwards.

Verification
REQ-027 dclk_i toggling every clk_i cycle (div-2), start_i pulse -> done_o once, period_o=2, high_o=1, timeout_o=0.
REQ-028 dclk_i with 8 cycles high and 8 low, start_i mid-high-phase -> first low-to-high ignored until a true rise; period_o=16, high_o=8.
REQ-029 dclk_i held 0, TMO_CYC=100 -> done_o exactly 100 cycles after entering ARM, timeout_o=1, period_o=0.
REQ-030 dclk_i period equals TMO_CYC=100 -> valid result period_o=100, timeout_o=0; period 101 -> timeout_o=1.
REQ-031 rstn_i=0 for one cycle during MEAS, dclk_i=1 -> busy_o=0 next cycle, no done_o, no spurious result; a new start_i then measures correctly.
REQ-032 start_i held high continuously, or pulsed during busy -> exactly one measurement per IDLE entry, with a new measurement starting on each done_o cycle.
